// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a combinational instruction memory.
// Holds the byte-addressed PC, drives the word address, and captures fetched
// instructions into a one-entry valid/ready register toward decode. Applies
// redirects from execute (flushing the stale entry) and supports halting.
// Optional build macro MISALIGN_TRAP_EN: a redirect whose target is not
// word-aligned enters a TRAP state and raises fetch_fault until reset.
// Without it, the target's low two bits are ignored.
module fetch_ctrl #(
    parameter int              alen     = 6,
    parameter int              ilen     = 32,
    parameter logic [alen+1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [alen-1:0] imem_addr,
    input  logic [ilen-1:0] imem_instr,
    input  logic            redirect,
    input  logic [alen+1:0] redirect_pc,
    input  logic            halt_req,
    output logic [ilen-1:0] instr,
    output logic [alen+1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            halted,
    output logic            fetch_fault
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`endif

    state_t          state_q, state_d;
    logic [alen+1:0] pc_q, pc_d;
    logic [ilen-1:0] instr_q, instr_d;
    logic [alen+1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            load;
    logic [alen+1:0] target_pc;

    // Redirect targets are always forced onto a word boundary.
    assign target_pc = {redirect_pc[alen+1:2], 2'b00};
    // The output register can take new data when empty or being drained now.
    assign load      = !valid_q || instr_ready;

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned;
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    // Low target bits are deliberately discarded in this build.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_pc[1:0];
    assign fetch_fault        = 1'b0;
`endif

    assign imem_addr   = pc_q[alen+1:2];
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);

    // Next-state logic: redirect beats halt, halt beats capture, else hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
`ifdef MISALIGN_TRAP_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = TRAP;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = target_pc;
                    end
`else
                    pc_d = target_pc;
`endif
                end else if (halt_req) begin
                    state_d = HALT;
                    if (instr_ready) valid_d = 1'b0;
                end else if (load) begin
                    instr_d    = imem_instr;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + (alen+2)'(4);
                end
            end
            HALT: begin
                if (redirect) begin
                    valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = TRAP;
                        fault_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        pc_d    = target_pc;
                    end
`else
                    state_d = RUN;
                    pc_d    = target_pc;
`endif
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                // TRAP (or an unreachable encoding): frozen until reset.
                state_d = state_q;
            end
        endcase
    end

    // State registers; reset overrides every other condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
`endif

endmodule
